// File: rtl/stim_driver_pkg.sv
// Shared types and constants for the stimulus driver.
package stim_driver_pkg;

  // Probe-measurement FSM states.
  typedef enum logic [2:0] {
    StFlush,
    StArmed,
    StCount,
    StDone,
    StFail
  } state_e;

  // Widest supported result; users slice DELAY_INVALID down to their DLY_W.
  localparam int unsigned DelayMaxW = 64;
  localparam logic [DelayMaxW-1:0] DELAY_INVALID = '1;

endpackage

// File: rtl/stim_delay_line.sv
// Fixed-depth register delay line, async active-high reset to 0.
// LATENCY = 0 degenerates to a wire.
module stim_delay_line #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 3
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (LATENCY == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_dut ^ reset;
    assign data_o = data_i;
  end else begin : g_pipe
    logic [LATENCY-1:0][WIDTH-1:0] stage_q, stage_d;

    // Shift one stage toward the output every cycle.
    always_comb begin
      stage_d    = stage_q;
      stage_d[0] = data_i;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Stage registers.
    always_ff @(posedge clk_dut or posedge reset) begin
      if (reset) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign data_o = stage_q[LATENCY-1];
  end

endmodule

// File: rtl/stim_driver.sv
// Stimulus driver: forwards LFSR operands to the DUT, injects a zero probe pair
// at a programmable slot and measures DUT pipeline latency; supplies
// monitor-aligned delayed copies of the driven operands.
// Build option: STIM_DRIVER_DELAY_MEAS_EN compiles in the FSM, probe injection
// and delay measurement; without it operands pass straight through.
module stim_driver
  import stim_driver_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned SLOT_W     = 16,
  parameter int unsigned PROBE_SLOT = 16'hEEEE,
  parameter int unsigned DLY_W      = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_rand_a,
  input  logic [WIDTH-1:0] i_rand_b,
  input  logic [WIDTH-1:0] i_dut_out,
  input  logic             i_remeasure,
  output logic [WIDTH-1:0] o_drive_a,
  output logic [WIDTH-1:0] o_drive_b,
  output logic [WIDTH-1:0] o_drive_delayed_a,
  output logic [WIDTH-1:0] o_drive_delayed_b,
  output logic [DLY_W-1:0] o_dut_delay,
  output logic             o_delay_valid,
  output logic             o_timeout
);

  localparam logic [DLY_W-1:0] DelayInvalid = DELAY_INVALID[DLY_W-1:0];

  logic [SLOT_W-1:0] slot_q, slot_d;

  // Free-running slot counter, wraps naturally.
  always_comb begin
    slot_d = slot_q + SLOT_W'(1);
  end

  // Slot counter register.
  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

`ifdef STIM_DRIVER_DELAY_MEAS_EN
  state_e            state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [DLY_W-1:0]  res_q, res_d;
  logic              probe;

  assign probe = (state_q == StArmed) && (slot_q == SLOT_W'(PROBE_SLOT));

  // FSM state register.
  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      state_q <= StFlush;
    end else begin
      state_q <= state_d;
    end
  end

  // Delay counter and latched result.
  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      dly_q <= '0;
      res_q <= '0;
    end else begin
      dly_q <= dly_d;
      res_q <= res_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    res_d   = res_q;
    unique case (state_q)
      StFlush: begin
        // Wait for the DUT to drain whatever it held across reset.
        if (i_dut_out == '0) state_d = StArmed;
      end
      StArmed: begin
        if (probe) begin
          state_d = StCount;
          dly_d   = DLY_W'(1);
        end
      end
      StCount: begin
        if (i_dut_out == '0) begin
          state_d = StDone;
          res_d   = dly_q;
        end else if (dly_q == DLY_W'(TIMEOUT)) begin
          state_d = StFail;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      StDone, StFail: begin
        if (i_remeasure) state_d = StArmed;
      end
      default: state_d = StFlush;
    endcase
  end

  // Output decode: probe mux and status.
  always_comb begin
    o_drive_a     = probe ? '0 : i_rand_a;
    o_drive_b     = probe ? '0 : i_rand_b;
    o_delay_valid = (state_q == StDone);
    o_timeout     = (state_q == StFail);
    o_dut_delay   = (state_q == StDone) ? res_q : DelayInvalid;
  end
`else
  logic unused_meas;
  assign unused_meas = ^{i_remeasure, i_dut_out, SLOT_W'(PROBE_SLOT), DLY_W'(TIMEOUT)};

  // Pass-through operands, measurement outputs tied off.
  always_comb begin
    o_drive_a     = i_rand_a;
    o_drive_b     = i_rand_b;
    o_delay_valid = 1'b0;
    o_timeout     = 1'b0;
    o_dut_delay   = DelayInvalid;
  end
`endif

  stim_delay_line #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY)
  ) u_dly_a (
    .clk_dut(clk_dut),
    .reset  (reset),
    .data_i (o_drive_a),
    .data_o (o_drive_delayed_a)
  );

  stim_delay_line #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY)
  ) u_dly_b (
    .clk_dut(clk_dut),
    .reset  (reset),
    .data_i (o_drive_b),
    .data_o (o_drive_delayed_b)
  );

endmodule

// File: tb/tb_stim_driver.sv
// Self-checking bench for stim_driver: hand-derived vector table after reset,
// randomized operands against a timestamp-based reference model, and
// hand-written sequences for re-arm, timeout and reset mid-count.
module tb_stim_driver;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned LATENCY    = 3;
  localparam int unsigned SLOT_W     = 4;
  localparam int unsigned PROBE_SLOT = 5;
  localparam int unsigned DLY_W      = 16;
  localparam int unsigned TIMEOUT    = 8;
  localparam int          SLOTS      = 1 << SLOT_W;
  localparam logic [DLY_W-1:0] Invalid = '1;

`ifdef STIM_DRIVER_DELAY_MEAS_EN
  localparam bit MeasEn = 1'b1;
`else
  localparam bit MeasEn = 1'b0;
`endif

  // Reference-model phases.
  localparam int PhWaitQuiet = 0, PhArmed = 1, PhMeasuring = 2, PhHaveResult = 3, PhTimedOut = 4;

  logic             clk_dut = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] rand_a = 32'h1;
  logic [WIDTH-1:0] rand_b = 32'h1;
  logic [WIDTH-1:0] dut_out;
  logic             remeasure = 1'b0;
  logic [WIDTH-1:0] drive_a, drive_b, dly_a, dly_b;
  logic [DLY_W-1:0] dut_delay;
  logic             delay_valid, timeout_o;

  always #5 clk_dut = ~clk_dut;

  stim_driver #(
    .WIDTH     (WIDTH),
    .LATENCY   (LATENCY),
    .SLOT_W    (SLOT_W),
    .PROBE_SLOT(PROBE_SLOT),
    .DLY_W     (DLY_W),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_dut          (clk_dut),
    .reset            (reset),
    .i_rand_a         (rand_a),
    .i_rand_b         (rand_b),
    .i_dut_out        (dut_out),
    .i_remeasure      (remeasure),
    .o_drive_a        (drive_a),
    .o_drive_b        (drive_b),
    .o_drive_delayed_a(dly_a),
    .o_drive_delayed_b(dly_b),
    .o_dut_delay      (dut_delay),
    .o_delay_valid    (delay_valid),
    .o_timeout        (timeout_o)
  );

  // Arithmetic DUT model: a+b through two registers; mode 1 = stuck at 1, mode 2 = idle zero.
  logic [WIDTH-1:0] p1, p2;
  int dut_mode = 0;
  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= drive_a + drive_b;
      p2 <= p1;
    end
  end
  assign dut_out = (dut_mode == 1) ? 32'h1 : (dut_mode == 2) ? 32'h0 : p2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: cycle index since reset, phase and probe timestamp.
  int cyc, ph, probe_c, res;
  int last_probe = -1000;
  logic [WIDTH-1:0] hist_a[$], hist_b[$];

  logic [WIDTH-1:0] s_da, s_dla;
  logic [DLY_W-1:0] s_dly;
  logic             s_v, s_to;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             probe;
    logic             valid;
    logic [DLY_W-1:0] dly;
  } vec_t;
  vec_t tab[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_nz();
    logic [WIDTH-1:0] v;
    do v = $urandom; while (v == '0);
    return v;
  endfunction

  task automatic model_reset();
    cyc = 0;
    ph  = PhWaitQuiet;
    hist_a.delete();
    hist_b.delete();
    for (int i = 0; i < LATENCY; i++) begin
      hist_a.push_back('0);
      hist_b.push_back('0);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic run_cycle(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic rm,
                           output logic [WIDTH-1:0] o_da, output logic [WIDTH-1:0] o_dla,
                           output logic [DLY_W-1:0] o_dly, output logic o_v, output logic o_to);
    logic             probe_now;
    logic [WIDTH-1:0] e_da, e_db, pre_out;
    logic [DLY_W-1:0] e_dly;
    int               el;
    rand_a    = a;
    rand_b    = b;
    remeasure = rm;
    #1;
    probe_now = MeasEn && (ph == PhArmed) && ((cyc % SLOTS) == PROBE_SLOT);
    e_da      = probe_now ? '0 : a;
    e_db      = probe_now ? '0 : b;
    e_dly     = (MeasEn && ph == PhHaveResult) ? DLY_W'(res) : Invalid;
    check("drive_a", drive_a, e_da);
    check("drive_b", drive_b, e_db);
    check("delayed_a", dly_a, hist_a[0]);
    check("delayed_b", dly_b, hist_b[0]);
    check("dut_delay", dut_delay, e_dly);
    check("delay_valid", delay_valid, MeasEn && ph == PhHaveResult);
    check("timeout", timeout_o, MeasEn && ph == PhTimedOut);
    o_da    = drive_a;
    o_dla   = dly_a;
    o_dly   = dut_delay;
    o_v     = delay_valid;
    o_to    = timeout_o;
    pre_out = dut_out;
    @(posedge clk_dut);
    hist_a.push_back(e_da);
    hist_b.push_back(e_db);
    void'(hist_a.pop_front());
    void'(hist_b.pop_front());
    if (ph == PhWaitQuiet) begin
      if (pre_out == '0) ph = PhArmed;
    end else if (ph == PhArmed) begin
      if (probe_now) begin
        ph         = PhMeasuring;
        probe_c    = cyc;
        last_probe = cyc;
      end
    end else if (ph == PhMeasuring) begin
      el = cyc - probe_c;
      if (pre_out == '0) begin
        ph  = PhHaveResult;
        res = el;
      end else if (el == TIMEOUT) begin
        ph = PhTimedOut;
      end
    end else if (rm) begin
      ph = PhArmed;
    end
    cyc++;
    @(negedge clk_dut);
  endtask

  // Assert reset mid-cycle and check outputs respond immediately.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_drive_a", drive_a, rand_a);
    check("rst_drive_b", drive_b, rand_b);
    check("rst_delayed_a", dly_a, 32'h0);
    check("rst_delayed_b", dly_b, 32'h0);
    check("rst_dut_delay", dut_delay, Invalid);
    check("rst_delay_valid", delay_valid, 1'b0);
    check("rst_timeout", timeout_o, 1'b0);
    model_reset();
    repeat (2) @(posedge clk_dut);
    @(negedge clk_dut);
    reset = 1'b0;
  endtask

  task automatic rand_cycles(input int n, input int rm_one_in);
    for (int i = 0; i < n; i++) begin
      run_cycle(rnd_nz(), rnd_nz(), ($urandom_range(rm_one_in - 1, 0) == 0), s_da, s_dla, s_dly,
                s_v, s_to);
    end
  endtask

  task automatic wait_valid(input string name, input int budget, output bit found);
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      run_cycle(rnd_nz(), rnd_nz(), 1'b0, s_da, s_dla, s_dly, s_v, s_to);
      if (s_v) found = 1'b1;
    end
    check({name, "_reached"}, found, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   found;
    int   sc, zeros;
    logic [WIDTH-1:0] ea;

    for (int i = 0; i < 12; i++) begin
      tab[i].a     = 32'h1111_0001 + 32'(i * 3);
      tab[i].b     = 32'h0200_0000 + 32'(i);
      tab[i].probe = MeasEn && (i == 5);
      tab[i].valid = MeasEn && (i >= 8);
      tab[i].dly   = (MeasEn && i >= 8) ? 16'd2 : Invalid;
    end

    do_reset();

    // Vector table: probe in cycle 5, 2-stage DUT reports 2 from cycle 8.
    for (int i = 0; i < 12; i++) begin
      run_cycle(tab[i].a, tab[i].b, 1'b0, s_da, s_dla, s_dly, s_v, s_to);
      check("tab_drive_a", s_da, tab[i].probe ? 32'h0 : tab[i].a);
      if (i >= 3) ea = tab[i-3].probe ? 32'h0 : tab[i-3].a;
      else ea = '0;
      check("tab_delayed_a", s_dla, ea);
      check("tab_valid", s_v, tab[i].valid);
      check("tab_delay", s_dly, tab[i].dly);
    end

    rand_cycles(60, 10);

`ifdef STIM_DRIVER_DELAY_MEAS_EN
    // Re-arm: valid drops next cycle, re-probe yields the same delay.
    wait_valid("rearm_pre", 60, found);
    run_cycle(rnd_nz(), rnd_nz(), 1'b1, s_da, s_dla, s_dly, s_v, s_to);
    run_cycle(rnd_nz(), rnd_nz(), 1'b0, s_da, s_dla, s_dly, s_v, s_to);
    check("rearm_drop", s_v, 1'b0);
    wait_valid("rearm_post", 40, found);
    check("rearm_delay", s_dly, 16'd2);

    // Timeout: stuck DUT, o_timeout rises TIMEOUT+1 cycles after the probe.
    dut_mode = 1;
    run_cycle(rnd_nz(), rnd_nz(), 1'b1, s_da, s_dla, s_dly, s_v, s_to);
    found = 1'b0;
    sc    = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      sc = cyc;
      run_cycle(rnd_nz(), rnd_nz(), 1'b0, s_da, s_dla, s_dly, s_v, s_to);
      if (s_to) found = 1'b1;
    end
    check("timeout_reached", found, 1'b1);
    check("timeout_cycle", sc - last_probe, TIMEOUT + 1);
    check("timeout_delay", s_dly, Invalid);
    check("timeout_valid", s_v, 1'b0);

    // Reset mid-count, hold in flush while the DUT is busy, then measure again.
    run_cycle(rnd_nz(), rnd_nz(), 1'b1, s_da, s_dla, s_dly, s_v, s_to);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      run_cycle(rnd_nz(), rnd_nz(), 1'b0, s_da, s_dla, s_dly, s_v, s_to);
      if (ph == PhMeasuring) found = 1'b1;
    end
    check("midcount_entered", found, 1'b1);
    run_cycle(rnd_nz(), rnd_nz(), 1'b0, s_da, s_dla, s_dly, s_v, s_to);
    do_reset();
    zeros = 0;
    for (int k = 0; k < 20; k++) begin
      run_cycle(rnd_nz(), rnd_nz(), 1'b0, s_da, s_dla, s_dly, s_v, s_to);
      if (s_da == '0) zeros++;
    end
    check("flush_hold_noprobe", zeros, 0);
    check("flush_hold_valid", s_v, 1'b0);
    dut_mode = 2;
    run_cycle(rnd_nz(), rnd_nz(), 1'b0, s_da, s_dla, s_dly, s_v, s_to);
    dut_mode = 0;
    wait_valid("midcount_post", 40, found);
    check("midcount_delay", s_dly, 16'd2);
`else
    // Pass-through build: no probe at PROBE_SLOT, no result ever.
    for (int k = 0; k < 20; k++) begin
      sc = cyc;
      ea = rnd_nz();
      dut_mode = k % 3;
      run_cycle(ea, rnd_nz(), 1'b1, s_da, s_dla, s_dly, s_v, s_to);
      if ((sc % SLOTS) == PROBE_SLOT) check("nomeas_probe_slot", s_da, ea);
      check("nomeas_valid", s_v, 1'b0);
      check("nomeas_delay", s_dly, Invalid);
    end
    dut_mode = 0;
`endif

    rand_cycles(40, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stim_driver.md
# stim_driver

Parametrised stimulus driver for the arithmetic testbench. It forwards LFSR operands to the DUT and injects a zero probe pair into a programmable slot, then measures the DUT's pipeline latency in `clk_dut` cycles. It also supplies monitor-aligned copies of the operands actually driven, probe included, through a configurable delay line. It sits between the LFSR pair, the DUT and the result monitor.

## Interface
- `WIDTH`, 32: operand and DUT result width, ≥ 2.
- `LATENCY`, 3: depth of the monitor delay line in stages, ≥ 0.
- `SLOT_W`, 16: width of the free-running slot counter.
- `PROBE_SLOT`, 16'hEEEE: slot counter value at which the probe is injected, < 2^SLOT_W.
- `DLY_W`, 16: width of the measured-delay result.
- `TIMEOUT`, 1024: maximum cycles to wait for a probe result, ≥ 1, < 2^DLY_W - 1.
- `clk_dut` input 1: clock; all logic is rising-edge.
- `reset` input 1: asynchronous, active-high.
- `i_rand_a`, `i_rand_b` input WIDTH: LFSR operands, never all-zero in normal use.
- `i_dut_out` input WIDTH: DUT result.
- `i_remeasure` input 1: single-cycle request to re-arm the probe.
- `o_drive_a`, `o_drive_b` output WIDTH: operands to the DUT.
- `o_drive_delayed_a`, `o_drive_delayed_b` output WIDTH: `o_drive_*` delayed by LATENCY cycles.
- `o_dut_delay` output DLY_W: measured latency, or all-ones while invalid.
- `o_delay_valid` output 1: `o_dut_delay` holds a completed measurement.
- `o_timeout` output 1: the last probe got no zero result within TIMEOUT cycles.

## Operation
- **Slot counter.** `slot_cnt`, SLOT_W bits, +1 every cycle, wraps 2^SLOT_W-1 → 0, resets to 0.
- **FSM states.** FLUSH, ARMED, COUNT, DONE, FAIL. Reset state is FLUSH.
  - FLUSH → ARMED when `i_dut_out == 0`, so the DUT is quiescent after reset.
  - ARMED → COUNT in the probe cycle: state ARMED and `slot_cnt == PROBE_SLOT`.
  - COUNT → DONE when `i_dut_out == 0`; latch `dly_cnt` into the result.
  - COUNT → FAIL when `dly_cnt == TIMEOUT` and `i_dut_out != 0`.
  - DONE/FAIL → ARMED on `i_remeasure`; `i_remeasure` is ignored in every other state.
- **Probe injection.** In the probe cycle, `o_drive_a` and `o_drive_b` are 0. In all other cycles they equal `i_rand_a` and `i_rand_b`, combinationally.
- **Delay count.** `dly_cnt` loads 1 on entry to COUNT and increments each COUNT cycle without a match. A 1-stage registered DUT therefore reports 1. A combinational DUT is not measurable: its zero appears in the probe cycle, so it reports the next zero or times out.
- **Outputs.** `o_delay_valid` = state DONE. `o_timeout` = state FAIL. `o_dut_delay` = latched count in DONE, all-ones otherwise.
- **Re-arm timing.** After re-arm, the next probe waits for the next `PROBE_SLOT` match, up to 2^SLOT_W cycles.
- **Delay line.** LATENCY register stages carry the post-mux `o_drive_*`, so the injected zeros reach the monitor. LATENCY = 0 is a straight wire.
- **Reset mid-operation.** Asynchronous. The FSM returns to FLUSH, counters and delay-line stages clear to 0, and the latched result is lost.

## Timing
- **Reset values.** `o_drive_*` = `i_rand_*` (slot 0 ≠ PROBE_SLOT unless PROBE_SLOT = 0, in which case the probe waits for wrap). `o_drive_delayed_*` = 0, `o_dut_delay` = all-ones, `o_delay_valid` = 0, `o_timeout` = 0.
- **Drive path.** Zero-cycle latency through the mux.
- **Monitor path.** Exactly LATENCY cycles.
- **Result timing.** With the probe in cycle T and `i_dut_out == 0` sampled in cycle T+N, `o_delay_valid` rises in T+N+1 with `o_dut_delay` = N.
- **Timeout timing.** With no match, `o_timeout` rises in T+TIMEOUT+1.

## Configuration
- `STIM_DRIVER_DELAY_MEAS_EN` defined: the FSM, probe injection and delay count are compiled in.
- Undefined: `o_drive_*` = `i_rand_*` always. `o_dut_delay` is all-ones, `o_delay_valid` and `o_timeout` are tied to 0, and `i_remeasure` and `i_dut_out` are unused. The slot counter and delay line remain.

## Structure
- **Package `stim_driver_pkg`:** the state enum and `DELAY_INVALID` (all-ones, DLY_W).
- **Sub-module `stim_delay_line`:** parameters WIDTH and LATENCY, async reset to 0. It is instantiated twice, for a and b.

## Test plan
1. **2-stage DUT.** Model DUT as out = a+b registered 2 stages; reset, run to probe → `o_delay_valid` rises 3 cycles after probe with `o_dut_delay` = 2, and `o_drive_*` = 0 only in the probe cycle.
2. **Monitor alignment.** LATENCY = 3 → `o_drive_delayed_*` = 0 exactly 3 cycles after the probe and equals `o_drive_*` from 3 cycles earlier every cycle.
3. **Timeout.** DUT output stuck at 32'h1 after FLUSH, TIMEOUT = 8 → `o_timeout` = 1 at probe+9, `o_dut_delay` = 16'hFFFF, `o_delay_valid` = 0.
4. **Re-arm.** `i_remeasure` pulse in DONE → `o_delay_valid` drops the next cycle. Re-probe at the next PROBE_SLOT match (SLOT_W = 4, PROBE_SLOT = 5) gives the same delay value.
5. **Reset mid-count.** Assert reset during COUNT → outputs take reset values immediately, the FSM holds in FLUSH until `i_dut_out` = 0, then the measurement completes normally.
6. **Macro undefined.** With `STIM_DRIVER_DELAY_MEAS_EN` undefined, `o_drive_*` = `i_rand_*` at slot PROBE_SLOT, `o_delay_valid` stays 0 and `o_dut_delay` stays all-ones.
